// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the scoreboarded register file: read, write, issue and hazard signals.
// The master modport is the pipeline side; the slave modport is the register file.
interface regfile_sb_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic [AW-1:0]    ra1;
  logic [AW-1:0]    ra2;
  logic             use1;
  logic             use2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic             we3;
  logic [AW-1:0]    wa3;
  logic [WIDTH-1:0] wd3;
  logic             issue_en;
  logic [AW-1:0]    issue_dst;
  logic             flush;
  logic             busy1;
  logic             busy2;
  logic             stall;
  logic [AW:0]      pending;

  modport master (
    output ra1, ra2, use1, use2, we3, wa3, wd3, issue_en, issue_dst, flush,
    input  rd1, rd2, busy1, busy2, stall, pending
  );

  modport slave (
    input  ra1, ra2, use1, use2, we3, wa3, wd3, issue_en, issue_dst, flush,
    output rd1, rd2, busy1, busy2, stall, pending
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard: combinational reads/stall, writes and busy bits update on the edge.
// Optional REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports and masks their busy flag.
module regfile_sb #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave rf
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [AW:0]      pending;
  logic [AW:0]      pending_nxt;
  logic             inc;
  logic             dec;
  logic             byp1;
  logic             byp2;

  always_comb begin
    busy_nxt = busy;
    if (rf.flush) begin
      busy_nxt = '0;
    end else begin
      for (int r = 1; r < DEPTH; r++) begin
        if (rf.issue_en && rf.issue_dst == AW'(r))
          busy_nxt[r] = 1'b1;
        else if (rf.we3 && rf.wa3 == AW'(r))
          busy_nxt[r] = 1'b0;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  // A writeback to the register being issued this cycle does not retire it: the new producer wins.
  always_comb begin
    inc = rf.issue_en && (rf.issue_dst != '0) && !busy[rf.issue_dst];
    dec = rf.we3 && (rf.wa3 != '0) && busy[rf.wa3]
          && !(rf.issue_en && rf.issue_dst == rf.wa3);
    if (rf.flush)
      pending_nxt = '0;
    else
      pending_nxt = pending + (AW+1)'(inc) - (AW+1)'(dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++)
        mem[r] <= '0;
      busy    <= '0;
      pending <= '0;
    end else begin
      if (rf.we3 && rf.wa3 != '0)
        mem[rf.wa3] <= rf.wd3;
      busy    <= busy_nxt;
      pending <= pending_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = rf.we3 && (rf.wa3 == rf.ra1) && (rf.ra1 != '0);
  assign byp2 = rf.we3 && (rf.wa3 == rf.ra2) && (rf.ra2 != '0);
  assign rf.rd1 = byp1 ? rf.wd3 : (rf.ra1 == '0 ? '0 : mem[rf.ra1]);
  assign rf.rd2 = byp2 ? rf.wd3 : (rf.ra2 == '0 ? '0 : mem[rf.ra2]);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
  assign rf.rd1 = (rf.ra1 == '0) ? '0 : mem[rf.ra1];
  assign rf.rd2 = (rf.ra2 == '0) ? '0 : mem[rf.ra2];
`endif

  assign rf.busy1   = busy[rf.ra1] & ~byp1;
  assign rf.busy2   = busy[rf.ra2] & ~byp2;
  assign rf.stall   = (rf.use1 & rf.busy1) | (rf.use2 & rf.busy2);
  assign rf.pending = pending;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file with an integrated scoreboard for the pipelined MIPS core. It provides two combinational read ports, one synchronous write port, and a per-register busy bit. Issue marks a destination busy and writeback clears it. The block outputs a stall request when a consumer reads a pending register. It sits between decode (issue/read) and writeback, and replaces the flat storage-only register file.

Parameters:
WIDTH, 32, data word width in bits
AW, 5, register address width
DEPTH, 32, number of registers; must equal 2**AW; entry 0 hardwired to zero

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
ra1  input  AW  read address, port 1
ra2  input  AW  read address, port 2
use1  input  1  decode actually consumes ra1 this cycle
use2  input  1  decode actually consumes ra2 this cycle
rd1  output  WIDTH  read data, port 1
rd2  output  WIDTH  read data, port 2
we3  input  1  writeback enable
wa3  input  AW  writeback address
wd3  input  WIDTH  writeback data
issue_en  input  1  instruction issued with a register destination
issue_dst  input  AW  destination of the issued instruction
flush  input  1  discard all in-flight producers
busy1  output  1  ra1 currently pending
busy2  output  1  ra2 currently pending
stall  output  1  (use1 & busy1) | (use2 & busy2)
pending  output  AW+1  number of busy registers, 0..DEPTH-1

Behaviour:
- Reset (sync, takes priority over everything): all storage entries = 0, all busy bits = 0, pending = 0. After reset, rd1/rd2 = 0 and busy1/busy2/stall = 0.
- Register 0: reads always return 0. Writes to 0 are ignored. Issue to 0 is ignored. busy[0] is never set.
- Read: rd = storage[ra], combinational.
- Write: at the edge when we3 and wa3 != 0, storage[wa3] <= wd3.
- Busy update each edge, in priority order: reset > flush > per-register rules.
  - flush: all busy bits and pending go to 0. A concurrent issue is dropped. A concurrent we3 still writes storage.
  - Otherwise, for register r:
    - set if issue_en & issue_dst == r & r != 0.
    - else clear if we3 & wa3 == r.
    - Simultaneous issue and writeback to the same r: set wins, because the new producer supersedes the old one.
- Writeback to a non-busy register is legal: storage is updated, busy and pending are unchanged.
- pending is maintained incrementally and must always equal the popcount of the busy bits.
  - +1 when a clear bit becomes set.
  - -1 when a set bit clears.
  - Net 0 for re-issue of a busy register, or same-cycle issue and writeback on the same register.
  - Issue and writeback on different registers in the same cycle change pending by +1 and -1 respectively.
  - pending never wraps.
- busyN = busy[raN] (subject to bypass below). stall is purely combinational and has no registered latency.
- Latency: a write is visible on rd the cycle after its edge (same cycle with bypass). Busy is visible the cycle after issue.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-through forwarding. If we3 & wa3 == raN & raN != 0, then rdN = wd3 in the same cycle, and busyN is forced to 0 for that port, because the value is available now.
- Undefined: rdN returns the old storage value until after the edge, and busyN reflects busy[raN] unmodified.

Test Plan:
- Assert reset mid-run with busy[3], busy[7] set and storage[3] = 0xDEADBEEF; one cycle later, expect rd1 = 0 for ra1 = 3, pending = 0, and stall = 0.
- Write 0x12345678 to r0, then read ra1 = 0; expect rd1 = 0. Issue to r0; expect busy1 = 0 and pending unchanged.
- Issue r5, then set ra1 = 5 and use1 = 1; expect busy1 = 1, stall = 1, pending = 1. Then we3 with wa3 = 5 and wd3 = 0xA5A5A5A5.
  - With bypass: stall drops in the same cycle and rd1 = 0xA5A5A5A5.
  - Without bypass: stall drops the next cycle.
- In the same cycle, issue r9 and writeback r9 while busy[9] = 1; expect busy[9] = 1 and pending unchanged. Also issue r2 and writeback r4 (busy) in one cycle; expect pending net 0.
- Issue r1..r31 on consecutive cycles; expect pending = 31. Flush together with issue r10 and we3 to r10 with 0x55; expect pending = 0, busy[10] = 0, and storage[10] = 0x55.
- Set use1 = 0, use2 = 1, with ra1 busy and ra2 not busy; expect stall = 0. Then make ra2 busy; expect stall = 1.
